// File: rtl/acc_seq.sv
// Beat sequencer for one MAC-accumulate unit: walks step/output/channel indices
// for a full layer pass and reports done once every accumulated result has returned.
module acc_seq #(
  parameter int STEP_W  = 12,
  parameter int OUT_W   = 12,
  parameter int CH_W    = 8,
  parameter int OUTST_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [STEP_W-1:0] cfg_steps,
  input  logic [OUT_W-1:0]  cfg_outputs,
  input  logic [CH_W-1:0]   cfg_channels,
  input  logic              hold,
  input  logic              res_valid,
  output logic              acc_en,
  output logic              acc_first,
  output logic              acc_last,
  output logic [STEP_W-1:0] step_idx,
  output logic [OUT_W-1:0]  out_idx,
  output logic [CH_W-1:0]   ch_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   steps_q, steps_d, step_q, step_d;
  logic [OUT_W-1:0]    outs_q, outs_d, out_q, out_d;
  logic [CH_W-1:0]     chs_q, chs_d, ch_q, ch_d;
  logic [OUTST_W-1:0]  outst_q, outst_d;
  logic                en_q, en_d, first_q, first_d, last_q, last_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                inc, step_end, out_end, ch_end;

  assign inc      = en_q & last_q;
  assign step_end = (step_q == steps_q - STEP_W'(1));
  assign out_end  = (out_q == outs_q - OUT_W'(1));
  assign ch_end   = (ch_q == chs_q - CH_W'(1));

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    outs_d  = outs_q;
    chs_d   = chs_q;
    step_d  = step_q;
    out_d   = out_q;
    ch_d    = ch_q;
    outst_d = outst_q;
    en_d    = 1'b0;
    first_d = first_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    // In-flight results: a same-cycle issue and return cancel out.
    if (inc && !res_valid) begin
      if (&outst_q) err_d = 1'b1;
      else          outst_d = outst_q + OUTST_W'(1);
    end else if (!inc && res_valid) begin
      if (outst_q == '0) err_d = 1'b1;
      else               outst_d = outst_q - OUTST_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          steps_d = cfg_steps;
          outs_d  = cfg_outputs;
          chs_d   = cfg_channels;
          step_d  = '0;
          out_d   = '0;
          ch_d    = '0;
          err_d   = 1'b0;
          if (cfg_steps == '0 || cfg_outputs == '0 || cfg_channels == '0) begin
            done_d  = 1'b1;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            // Beat 0 goes out on the accepting edge.
            state_d = RUN;
            busy_d  = 1'b1;
            en_d    = 1'b1;
            first_d = 1'b1;
            last_d  = (cfg_steps == STEP_W'(1));
          end
        end
      end
      RUN: begin
        if (step_end && out_end && ch_end) begin
          state_d = DRAIN;
        end else if (!hold) begin
          en_d = 1'b1;
          if (step_end) begin
            step_d = '0;
            if (out_end) begin
              out_d = '0;
              ch_d  = ch_q + CH_W'(1);
            end else begin
              out_d = out_q + OUT_W'(1);
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
          first_d = (step_d == '0);
          last_d  = (step_d == steps_q - STEP_W'(1));
        end
      end
      DRAIN: begin
        if (!inc && outst_d == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      steps_q <= '0;
      outs_q  <= '0;
      chs_q   <= '0;
      step_q  <= '0;
      out_q   <= '0;
      ch_q    <= '0;
      outst_q <= '0;
      en_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      outs_q  <= outs_d;
      chs_q   <= chs_d;
      step_q  <= step_d;
      out_q   <= out_d;
      ch_q    <= ch_d;
      outst_q <= outst_d;
      en_q    <= en_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign acc_en    = en_q;
  assign acc_first = first_q;
  assign acc_last  = last_q;
  assign step_idx  = step_q;
  assign out_idx   = out_q;
  assign ch_idx    = ch_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_acc_seq.sv
// Scoreboard bench for acc_seq: stimulus queues expected beats and done cycles,
// a negedge monitor pops and compares; a returner echoes acc_last beats as res_valid.
module tb_acc_seq;

  typedef struct packed {
    logic [11:0] step;
    logic [11:0] out;
    logic [7:0]  ch;
    logic        first;
    logic        last;
  } beat_t;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, hold = 1'b0;
  logic        stray = 1'b0, rp = 1'b0;
  logic [11:0] cfg_steps = '0, cfg_outputs = '0;
  logic [7:0]  cfg_channels = '0;
  logic        res_valid;
  logic        acc_en, acc_first, acc_last, busy, done, err;
  logic [11:0] step_idx, out_idx;
  logic [7:0]  ch_idx;

  int    cyc = 0, pass_cnt = 0, tot_cnt = 0, rdly = 4, s = 0;
  bit    ret [8192];
  beat_t bq[$];
  int    dq[$];

  assign res_valid = rp | stray;

  acc_seq dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_steps(cfg_steps), .cfg_outputs(cfg_outputs), .cfg_channels(cfg_channels),
    .hold(hold), .res_valid(res_valid),
    .acc_en(acc_en), .acc_first(acc_first), .acc_last(acc_last),
    .step_idx(step_idx), .out_idx(out_idx), .ch_idx(ch_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input int st, input int ou, input int ch);
    @(posedge clk); #1;
    cfg_steps = 12'(st); cfg_outputs = 12'(ou); cfg_channels = 8'(ch);
    start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_beats(input int st, input int ou, input int ch);
    for (int c = 0; c < ch; c++)
      for (int o = 0; o < ou; o++)
        for (int k = 0; k < st; k++)
          bq.push_back('{step: 12'(k), out: 12'(o), ch: 8'(c),
                         first: (k == 0), last: (k == st - 1)});
  endtask

  // Result sink model: each acc_last beat returns rdly cycles later.
  always @(negedge clk) begin
    if (!rstn) ret = '{default: 1'b0};
    else if (acc_en && acc_last) ret[(cyc + rdly) % 8192] = 1'b1;
  end
  initial forever begin
    @(posedge clk); #1;
    rp = ret[cyc % 8192];
  end

  // Monitor
  always @(negedge clk) begin
    beat_t got, exp;
    int    dexp;
    if (!rstn) begin
      bq.delete();
      dq.delete();
    end else begin
      if (acc_en) begin
        got = '{step: step_idx, out: out_idx, ch: ch_idx, first: acc_first, last: acc_last};
        if (bq.size() == 0) begin
          tot_cnt++;
          $display("FAIL beat_unexpected: got beat %0h expected no beat (cycle %0d)", got, cyc);
        end else begin
          exp = bq.pop_front();
          chk("beat", got, exp);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          tot_cnt++;
          $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
        end else begin
          dexp = dq.pop_front();
          chk("done_cycle", cyc, dexp);
        end
      end
    end
  end

  initial begin
    wait_cyc(3);
    chk("reset_outs", {acc_en, acc_first, acc_last, busy, done, err, step_idx, out_idx, ch_idx}, '0);
    rstn = 1'b1;
    wait_cyc(2);

    // 3 steps x 2 outputs x 2 channels, no hold
    rdly = 4;
    start_pass(3, 2, 2); push_beats(3, 2, 2); dq.push_back(s + 17);
    wait_cyc(15); chk("s1_busy_run", busy, 1);
    wait_cyc(1);  chk("s1_busy_done", busy, 0); chk("s1_err", err, 0);
    wait_cyc(4);

    // Same pass with a 3-cycle hold while beat 4 is presented
    start_pass(3, 2, 2); push_beats(3, 2, 2); dq.push_back(s + 20);
    wait_cyc(4); hold = 1'b1;
    wait_cyc(2);
    chk("s2_gap_en", acc_en, 0);
    chk("s2_gap_idx", {step_idx, out_idx, ch_idx}, {12'd1, 12'd1, 8'd0});
    wait_cyc(1); hold = 1'b0;
    wait_cyc(12); chk("s2_busy_done", busy, 0); chk("s2_err", err, 0);
    wait_cyc(4);

    // Zero outputs: immediate done, nothing issued
    start_pass(3, 0, 2); dq.push_back(s + 1);
    chk("s4_busy0", busy, 0);
    wait_cyc(1); chk("s4_busy1", busy, 0);
    wait_cyc(3);

    // Stray result in IDLE sets sticky err
    stray = 1'b1; wait_cyc(1); stray = 1'b0;
    chk("s5_err_set", err, 1);
    wait_cyc(3); chk("s5_err_sticky", err, 1);

    // Single-step outputs; rdly=1 makes returns coincide with last beats
    rdly = 1;
    start_pass(1, 3, 1); push_beats(1, 3, 1); dq.push_back(s + 5);
    chk("s3_err_cleared", err, 0);
    wait_cyc(4); chk("s3_err", err, 0); chk("s3_busy_done", busy, 0);
    wait_cyc(3);

    // Reset mid-run, then a clean pass with an ignored start while busy
    rdly = 4;
    start_pass(3, 2, 2); push_beats(3, 2, 2);
    wait_cyc(5);
    rstn = 1'b0; #1;
    chk("s6_reset_outs", {acc_en, acc_first, acc_last, busy, done, err, step_idx, out_idx, ch_idx}, '0);
    wait_cyc(2); rstn = 1'b1;
    wait_cyc(6); chk("s6_idle_busy", busy, 0);
    start_pass(3, 2, 2); push_beats(3, 2, 2); dq.push_back(s + 17);
    wait_cyc(3);
    cfg_steps = 12'd1; cfg_outputs = 12'd1; cfg_channels = 8'd1; start = 1'b1;
    wait_cyc(1); start = 1'b0;
    wait_cyc(12); chk("s6_busy_done", busy, 0); chk("s6_err", err, 0);
    wait_cyc(4);

    chk("beats_left", bq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/acc_seq.md
Name: acc_seq

Overview:
- Sequencer that drives one acc (MAC-accumulate) unit through a full convolution/FC layer pass.
- Emits the per-beat enable, first/last framing, and the step/output/channel indices used by the feature, weight and bias memories.
- Tracks results still in flight and signals completion only after every accumulated output has returned through the unit's q_en.
- Sits between the layer controller (start/done) and the acc datapath plus its operand memories.

Parameters:
STEP_W, 12, width of accumulation-step counter (beats per output, i.e. IN_CH*K*K/INPUT_NUM)
OUT_W, 12, width of output-position counter (outputs per channel)
CH_W, 8, width of output-channel counter (selects weight bank and bias)
OUTST_W, 5, width of in-flight result counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin a pass; ignored unless idle
cfg_steps  in  STEP_W  beats per output; sampled on accepted start
cfg_outputs  in  OUT_W  outputs per channel; sampled on accepted start
cfg_channels  in  CH_W  output channels; sampled on accepted start
hold  in  1  backpressure from operand fetch / result sink; freezes issue
res_valid  in  1  result strobe from acc q_en
acc_en  out  1  beat valid to acc en
acc_first  out  1  to acc first_data; high on step 0 of each output
acc_last  out  1  to acc last_data; high on step cfg_steps-1 of each output
step_idx  out  STEP_W  current step (feature/weight address low part)
out_idx  out  OUT_W  current output position
ch_idx  out  CH_W  current channel (weight bank / bias select)
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at pass completion
err  out  1  sticky: unexpected res_valid or outstanding overflow; cleared on accepted start

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All outputs and counters reset to 0; state IDLE. Reset mid-pass abandons the pass; no done pulse is generated.
- All outputs are registered.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 latches the cfg_* inputs, clears err and the indices.
  - If any cfg_* value is 0: stay IDLE and pulse done the next cycle, with no beats issued.
  - Otherwise go to RUN.
- RUN:
  - At each clock edge with hold=0, load the next beat: acc_en=1, indices set to the next tuple, acc_first=(step==0), acc_last=(step==cfg_steps-1).
  - The first beat is loaded on the same edge that accepts start, so acc_en is high in the cycle immediately after start.
  - With hold=1 at an edge: acc_en<=0, indices and flags frozen, no beat lost or duplicated.
- Index order: step innermost, then out_idx, then ch_idx. Each counter wraps to 0 when it passes cfg-1 and carries into the next.
- After the edge that loads the final beat (ch=cfg_channels-1, out=cfg_outputs-1, step=cfg_steps-1), the next edge clears acc_en and moves to DRAIN. That transition happens regardless of hold.
- cfg_steps==1: every beat has acc_first=acc_last=1.
- Outstanding counter:
  - +1 in each cycle where acc_en&acc_last=1.
  - -1 in each cycle where res_valid=1.
  - Both in the same cycle: no change.
  - res_valid while the count is 0 (and no same-cycle increment): count stays 0, err<=1.
  - Increment at all-ones: count saturates, err<=1.
- DRAIN: when outstanding==0 and no increment is pending, done<=1 for one cycle, busy<=0, go to IDLE.
- busy is high from the cycle after an accepted start until the cycle done is high; busy is 0 in the done cycle.
- start while busy is ignored, and cfg_* is not resampled.
- Total beats issued = cfg_steps*cfg_outputs*cfg_channels. Total last beats = cfg_outputs*cfg_channels.

Test Plan:
1. steps=3, outputs=2, channels=2, hold=0, bench returns res_valid 4 cycles after each last beat:
   - 12 consecutive acc_en cycles starting the cycle after start.
   - acc_first on beats 0,3,6,9; acc_last on beats 2,5,8,11.
   - ch_idx=0 for beats 0-5 and 1 for beats 6-11; out_idx 0,0,0,1,1,1,... .
   - done exactly 1 cycle after the 4th res_valid; err=0.
2. Same config, hold=1 for 3 cycles in the middle of beat 4:
   - Exactly 12 beats issued, same index sequence.
   - acc_en low for 3 cycles; indices stable during the gap.
3. steps=1, outputs=3, channels=1: 3 beats, each with acc_first=acc_last=1; done after the 3rd result.
4. cfg_outputs=0:
   - No acc_en.
   - done pulses 1 cycle after start; busy stays 0.
5. Extra res_valid in IDLE -> err=1, remains 1 until the next accepted start clears it. res_valid coinciding with an acc_last beat leaves the outstanding count unchanged.
6. rstn low mid-RUN (beat 5 of scenario 1) -> all outputs 0 immediately. After release: no done, IDLE, and a new start runs scenario 1 cleanly.
